// File: rtl/ad9363_pkg.sv
// Shared types and helpers for the AD9363 burst controller.
package ad9363_pkg;

    localparam int SAMPLE_W = 12;

    typedef struct packed {
        logic [SAMPLE_W-1:0] i;
        logic [SAMPLE_W-1:0] q;
    } iq_sample_t;

    typedef enum logic [2:0] {
        BS_IDLE  = 3'd0,
        BS_SETUP = 3'd1,
        BS_TX    = 3'd2,
        BS_RX    = 3'd3,
        BS_GUARD = 3'd4
    } burst_state_t;

    // Bits needed to hold a down-counter start value of n-1.
    function automatic int cnt_width(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ad9363_cycle_timer.sv
// Loadable down-counter; expire is high during the last of (load_val+1) cycles.
module ad9363_cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;
    logic         active;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            active <= 1'b1;
            cnt    <= load_val;
        end else if (active) begin
            if (cnt == '0) active <= 1'b0;
            else           cnt    <= cnt - 1'b1;
        end
    end

    assign expire = active && (cnt == '0);

endmodule

// File: rtl/ad9363_burst_ctrl.sv
// Burst sequencer: ENSM pin control, SETUP/GUARD timing and gated TX/RX sample streams.
module ad9363_burst_ctrl
    import ad9363_pkg::*;
#(
    parameter int LEN_W     = 16,
    parameter int SETUP_CYC = 8,
    parameter int GUARD_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_tx,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                cmd_abort,
    input  logic                src_valid,
    input  logic [SAMPLE_W-1:0] src_data_i,
    input  logic [SAMPLE_W-1:0] src_data_q,
    output logic                src_ready,
    output logic                tx_valid,
    output logic [SAMPLE_W-1:0] tx_data_i,
    output logic [SAMPLE_W-1:0] tx_data_q,
    input  logic                tx_ready,
    input  logic                rx_valid,
    input  logic [SAMPLE_W-1:0] rx_data_i,
    input  logic [SAMPLE_W-1:0] rx_data_q,
    output logic                rx_ready,
    output logic                snk_valid,
    output logic [SAMPLE_W-1:0] snk_data_i,
    output logic [SAMPLE_W-1:0] snk_data_q,
    input  logic                snk_ready,
    output logic                ensm_enable,
    output logic                ensm_txnrx,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                underrun
);

    localparam int TMR_MAX = (SETUP_CYC > GUARD_CYC) ? SETUP_CYC : GUARD_CYC;
    localparam int TMR_W   = cnt_width(TMR_MAX);
    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] GUARD_LD = TMR_W'(GUARD_CYC - 1);

    localparam logic [2:0] ST_IDLE  = BS_IDLE;
    localparam logic [2:0] ST_SETUP = BS_SETUP;
    localparam logic [2:0] ST_TX    = BS_TX;
    localparam logic [2:0] ST_RX    = BS_RX;
    localparam logic [2:0] ST_GUARD = BS_GUARD;

    logic [2:0]       state;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len_q;
    logic             tx_q;
    logic             abort_pend;
    logic             in_tx, in_rx, in_run;
    logic             cmd_fire, abort_now, beat, last_beat;
    logic             tmr_load, tmr_expire;
    logic [TMR_W-1:0] tmr_val;
    iq_sample_t       src_s, rx_s;

    assign in_tx     = (state == ST_TX);
    assign in_rx     = (state == ST_RX);
    assign in_run    = in_tx || in_rx || (state == ST_SETUP);
    assign busy      = (state != ST_IDLE);
    assign cmd_ready = !busy;
    assign cmd_fire  = cmd_valid && cmd_ready && (cmd_len != '0);
    assign abort_now = in_run && cmd_abort;

    // Streams are pure wiring; an abort cycle blocks the beat in both directions.
    assign src_s      = '{i: src_data_i, q: src_data_q};
    assign rx_s       = '{i: rx_data_i,  q: rx_data_q};
    assign tx_valid   = in_tx && src_valid && !cmd_abort;
    assign src_ready  = in_tx && tx_ready && !cmd_abort;
    assign tx_data_i  = src_s.i;
    assign tx_data_q  = src_s.q;
    assign snk_valid  = in_rx && rx_valid && !cmd_abort;
    assign rx_ready   = !in_rx || snk_ready || cmd_abort;
    assign snk_data_i = rx_s.i;
    assign snk_data_q = rx_s.q;

    assign beat      = (tx_valid && tx_ready) || (snk_valid && snk_ready);
    assign last_beat = beat && (count == len_q - 1'b1);

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        tmr_load = 1'b0;
        tmr_val  = GUARD_LD;
        if (cmd_fire) begin
            tmr_load = 1'b1;
            tmr_val  = SETUP_LD;
        end else if (abort_now || last_beat) begin
            tmr_load = 1'b1;
        end
    end

    ad9363_cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    // NOTE: command fields carry no reset; they are only read after a handshake loads them.
    always_ff @(posedge clk) begin
        if (cmd_fire) begin
            len_q <= cmd_len;
            tx_q  <= cmd_tx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            count       <= '0;
            abort_pend  <= 1'b0;
            ensm_enable <= 1'b0;
            ensm_txnrx  <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            done     <= 1'b0;
            aborted  <= 1'b0;
            underrun <= in_tx && tx_ready && !src_valid;
            if (abort_now) begin
                state       <= ST_GUARD;
                ensm_enable <= 1'b0;
                abort_pend  <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cmd_valid && cmd_len == '0) begin
                            done <= 1'b1;
                        end else if (cmd_fire) begin
                            count       <= '0;
                            abort_pend  <= 1'b0;
                            ensm_txnrx  <= cmd_tx;
                            ensm_enable <= 1'b1;
                            state       <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        if (tmr_expire) state <= tx_q ? ST_TX : ST_RX;
                    end
                    ST_TX, ST_RX: begin
                        if (beat) begin
                            count <= count + 1'b1;
                            if (last_beat) begin
                                state       <= ST_GUARD;
                                ensm_enable <= 1'b0;
                            end
                        end
                    end
                    ST_GUARD: begin
                        if (tmr_expire) begin
                            state   <= ST_IDLE;
                            done    <= 1'b1;
                            aborted <= abort_pend;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ad9363_burst_ctrl.sv
// Directed bench for ad9363_burst_ctrl: a burst table plus hand-written reset/abort sequences.
module tb_ad9363_burst_ctrl;
    import ad9363_pkg::*;

    localparam int LW    = 8;
    localparam int SETUP = 8;
    localparam int GUARD = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                cmd_valid, cmd_ready, cmd_tx, cmd_abort;
    logic [LW-1:0]       cmd_len;
    logic                src_valid, src_ready, tx_valid, tx_ready;
    logic [SAMPLE_W-1:0] src_data_i, src_data_q, tx_data_i, tx_data_q;
    logic                rx_valid, rx_ready, snk_valid, snk_ready;
    logic [SAMPLE_W-1:0] rx_data_i, rx_data_q, snk_data_i, snk_data_q;
    logic                ensm_enable, ensm_txnrx, busy, done, aborted, underrun;

    always #5 clk = ~clk;

    ad9363_burst_ctrl #(.LEN_W(LW), .SETUP_CYC(SETUP), .GUARD_CYC(GUARD)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tx(cmd_tx), .cmd_len(cmd_len),
        .cmd_abort(cmd_abort),
        .src_valid(src_valid), .src_data_i(src_data_i), .src_data_q(src_data_q), .src_ready(src_ready),
        .tx_valid(tx_valid), .tx_data_i(tx_data_i), .tx_data_q(tx_data_q), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data_i(rx_data_i), .rx_data_q(rx_data_q), .rx_ready(rx_ready),
        .snk_valid(snk_valid), .snk_data_i(snk_data_i), .snk_data_q(snk_data_q), .snk_ready(snk_ready),
        .ensm_enable(ensm_enable), .ensm_txnrx(ensm_txnrx),
        .busy(busy), .done(done), .aborted(aborted), .underrun(underrun)
    );

    typedef struct {
        bit tx;
        int len;
        int gap_start;    // first cycle (after handshake) with src_valid low
        int gap_len;
        bit snk_toggle;   // snk_ready 1,0,1,0,... from the first RX cycle
        int abort_after;  // pulse cmd_abort once this many beats have passed (-1: never)
        bit guard_abort;  // pulse cmd_abort in the 4th GUARD cycle
        int exp_beats;
        int exp_busy;
        int exp_en;
        int exp_guard;
        int exp_underrun;
        int exp_aborted;
    } vec_t;

    typedef struct {
        int beats, busy_cyc, en_cyc, guard_cyc, und_cyc;
        int done_cnt, done_cyc, ab_cnt, err;
    } stats_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit tx, int len, int gs, int gl, bit tog, int ab, bit gab,
                                int eb, int ebusy, int een, int eg, int eu, int eab);
        vec_t v;
        v.tx = tx; v.len = len; v.gap_start = gs; v.gap_len = gl; v.snk_toggle = tog;
        v.abort_after = ab; v.guard_abort = gab; v.exp_beats = eb; v.exp_busy = ebusy;
        v.exp_en = een; v.exp_guard = eg; v.exp_underrun = eu; v.exp_aborted = eab;
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the first cycle after the handshake edge.
    task automatic issue_cmd(input bit tx, input int len);
        cmd_valid = 1'b1;
        cmd_tx    = tx;
        cmd_len   = LW'(len);
        src_valid = 1'b1;
        rx_valid  = 1'b1;
        snk_ready = 1'b1;
        @(negedge clk);
        check($sformatf("cmd_ready_at_issue_len%0d", len), int'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_burst(input vec_t v, output stats_t s);
        bit ab_sent  = 1'b0;
        bit gab_sent = 1'b0;
        int limit    = v.len + 100;
        s = '{default: 0};
        issue_cmd(v.tx, v.len);
        for (int cyc = 1; cyc <= limit; cyc++) begin
            src_valid  = !(cyc >= v.gap_start && cyc < v.gap_start + v.gap_len);
            snk_ready  = (!v.snk_toggle || cyc <= SETUP) ? 1'b1 : ((cyc - SETUP - 1) % 2 == 0);
            rx_valid   = 1'b1;
            cmd_abort  = 1'b0;
            if (v.abort_after >= 0 && !ab_sent && s.beats == v.abort_after) begin
                cmd_abort = 1'b1;
                ab_sent   = 1'b1;
            end
            if (v.guard_abort && !gab_sent && s.guard_cyc == 3) begin
                cmd_abort = 1'b1;
                gab_sent  = 1'b1;
            end
            src_data_i = SAMPLE_W'(cyc * 7 + 1);
            src_data_q = SAMPLE_W'(cyc * 5 + 2);
            rx_data_i  = SAMPLE_W'(cyc * 11 + 3);
            rx_data_q  = SAMPLE_W'(cyc * 13 + 4);
            @(negedge clk);
            if (busy) s.busy_cyc++;
            if (ensm_enable) s.en_cyc++;
            if (busy && !ensm_enable) s.guard_cyc++;
            if (underrun) s.und_cyc++;
            if (cmd_ready !== !busy) s.err++;
            if (busy && ensm_txnrx !== v.tx) s.err++;
            if (!ensm_enable && (tx_valid || src_ready || snk_valid || !rx_ready)) s.err++;
            if (v.tx && (snk_valid || !rx_ready)) s.err++;
            if (!v.tx && (tx_valid || src_ready)) s.err++;
            if (tx_valid && tx_ready) begin
                s.beats++;
                if (tx_data_i !== src_data_i || tx_data_q !== src_data_q) s.err++;
            end
            if (snk_valid && snk_ready) begin
                s.beats++;
                if (snk_data_i !== rx_data_i || snk_data_q !== rx_data_q) s.err++;
            end
            if (aborted) begin
                s.ab_cnt++;
                if (!done) s.err++;
            end
            if (done) begin
                if (s.done_cnt == 0) s.done_cyc = cyc;
                s.done_cnt++;
            end
            @(posedge clk); #1;
            if (s.done_cnt != 0 && cyc >= s.done_cyc + 2) break;
        end
        cmd_abort = 1'b0;
    endtask

    vec_t   vecs[9];
    stats_t st;
    int     got;
    int     seen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // tx len gap gl tog abort gab | beats busy en guard und ab
        vecs[0] = mk(1,   4,  0, 0, 0, -1, 0,   4,  28,  12, 16, 0, 0); // basic TX
        vecs[1] = mk(0,   3,  0, 0, 1, -1, 0,   3,  29,  13, 16, 0, 0); // RX, snk_ready toggling
        vecs[2] = mk(1,   0,  0, 0, 0, -1, 0,   0,   0,   0,  0, 0, 0); // zero length
        vecs[3] = mk(1,  10, 11, 2, 0, -1, 0,  10,  36,  20, 16, 2, 0); // TX underrun gap
        vecs[4] = mk(1, 100,  0, 0, 0,  5, 0,   5,  30,  14, 16, 0, 1); // abort after 5 beats
        vecs[5] = mk(0,   1,  0, 0, 0, -1, 0,   1,  25,   9, 16, 0, 0); // single RX beat
        vecs[6] = mk(1, 255,  0, 0, 0, -1, 0, 255, 279, 263, 16, 0, 0); // maximum length
        vecs[7] = mk(0,   6,  0, 0, 0,  0, 0,   0,  17,   1, 16, 0, 1); // abort in SETUP
        vecs[8] = mk(1,   3,  0, 0, 0, -1, 1,   3,  27,  11, 16, 0, 0); // abort in GUARD ignored

        rst = 1'b1; cmd_valid = 1'b0; cmd_tx = 1'b0; cmd_len = '0; cmd_abort = 1'b0;
        src_valid = 1'b1; src_data_i = '0; src_data_q = '0; tx_ready = 1'b1;
        rx_valid = 1'b1; rx_data_i = '0; rx_data_q = '0; snk_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",        int'(busy),        0);
        check("rst_ensm_enable", int'(ensm_enable), 0);
        check("rst_ensm_txnrx",  int'(ensm_txnrx),  0);
        check("rst_done",        int'(done),        0);
        check("rst_aborted",     int'(aborted),     0);
        check("rst_underrun",    int'(underrun),    0);
        check("rst_cmd_ready",   int'(cmd_ready),   1);
        check("idle_tx_valid",   int'(tx_valid),    0);
        check("idle_src_ready",  int'(src_ready),   0);
        check("idle_snk_valid",  int'(snk_valid),   0);
        check("idle_rx_ready",   int'(rx_ready),    1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Abort while idle must do nothing.
        cmd_abort = 1'b1;
        @(posedge clk); #1;
        cmd_abort = 1'b0;
        @(negedge clk);
        check("idle_abort_busy",    int'(busy),    0);
        check("idle_abort_done",    int'(done),    0);
        check("idle_abort_aborted", int'(aborted), 0);
        @(posedge clk); #1;

        for (int k = 0; k < 9; k++) begin
            run_burst(vecs[k], st);
            check($sformatf("v%0d_beats", k),     st.beats,     vecs[k].exp_beats);
            check($sformatf("v%0d_busy_cyc", k),  st.busy_cyc,  vecs[k].exp_busy);
            check($sformatf("v%0d_enable_cyc", k), st.en_cyc,   vecs[k].exp_en);
            check($sformatf("v%0d_guard_cyc", k), st.guard_cyc, vecs[k].exp_guard);
            check($sformatf("v%0d_underrun", k),  st.und_cyc,   vecs[k].exp_underrun);
            check($sformatf("v%0d_done_cnt", k),  st.done_cnt,  1);
            check($sformatf("v%0d_done_cyc", k),  st.done_cyc,  vecs[k].exp_busy + 1);
            check($sformatf("v%0d_aborted", k),   st.ab_cnt,    vecs[k].exp_aborted);
            check($sformatf("v%0d_stream_err", k), st.err,      0);
        end

        // Reset in the middle of an RX burst after two beats.
        issue_cmd(1'b0, 10);
        got = 0;
        for (int c = 1; c <= 20 && got < 2; c++) begin
            @(negedge clk);
            if (snk_valid && snk_ready) got++;
            @(posedge clk); #1;
        end
        check("midrst_pre_beats", got, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy",        int'(busy),        0);
        check("midrst_ensm_enable", int'(ensm_enable), 0);
        check("midrst_done",        int'(done),        0);
        check("midrst_cmd_ready",   int'(cmd_ready),   1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done) seen++;
        end
        check("midrst_no_done", seen, 0);
        @(posedge clk); #1;
        run_burst(vecs[0], st);
        check("postrst_tx_beats",    st.beats,    4);
        check("postrst_tx_busy",     st.busy_cyc, 28);
        check("postrst_tx_done_cnt", st.done_cnt, 1);
        check("postrst_tx_err",      st.err,      0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
